// File: rtl/add_sub.sv
// 4-bit unsigned adder/subtractor with sign-magnitude result.
// One-cycle registered latency; synchronous active-high reset.
module add_sub_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (w_p & i_ci);

endmodule

module add_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       M,
  output logic [4:0] s,
  output logic       sign
);

  logic [3:0] w_bx;
  logic [4:0] w_c;
  logic [3:0] w_raw;
  logic       w_neg_en;
  logic [3:0] w_neg;
  logic [3:0] w_mag;
  logic [4:0] w_s;
  logic       w_sign;
  logic [4:0] r_s;
  logic       r_sign;

  // M inverts B and supplies the +1, giving a + ~b + 1 when subtracting
  assign w_bx   = b ^ {4{M}};
  assign w_c[0] = M;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    add_sub_fa u_fa (
      .i_a  (a[i]),
      .i_b  (w_bx[i]),
      .i_ci (w_c[i]),
      .o_s  (w_raw[i]),
      .o_co (w_c[i+1])
    );
  end

  // no carry out in subtract mode means a < b
  assign w_neg_en = M & ~w_c[4];
  assign w_neg    = ~w_raw + 4'd1;
  assign w_mag    = w_neg_en ? w_neg : w_raw;

  always_comb begin
    w_s    = {w_c[4], w_raw};
    w_sign = 1'b0;
    if (M) begin
      w_s    = {1'b0, w_mag};
      w_sign = w_neg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= 5'd0;
      r_sign <= 1'b0;
    end else begin
      r_s    <= w_s;
      r_sign <= w_sign;
    end
  end

  assign s    = r_s;
  assign sign = r_sign;

endmodule

// File: tb/tb_add_sub.sv
// Scoreboard bench for add_sub: driver queues expectations,
// monitor checks each result one cycle after issue.
module tb_add_sub;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       M;
  logic [4:0] s;
  logic       sign;

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [4:0] es;
    logic       esign;
  } vec_t;

  typedef struct {
    int         idx;
    logic [4:0] es;
    logic       esign;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  add_sub dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .M    (M),
    .s    (s),
    .sign (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$] = '{
    '{1'b1, 4'd9,  4'd6,  1'b1, 5'd0,  1'b0},
    '{1'b1, 4'd9,  4'd6,  1'b1, 5'd0,  1'b0},
    '{1'b0, 4'd9,  4'd6,  1'b1, 5'd3,  1'b0},
    '{1'b0, 4'd0,  4'd15, 1'b0, 5'd15, 1'b0},
    '{1'b0, 4'd15, 4'd0,  1'b1, 5'd15, 1'b0},
    '{1'b0, 4'd0,  4'd15, 1'b1, 5'd15, 1'b1},
    '{1'b0, 4'd15, 4'd15, 1'b0, 5'd30, 1'b0},
    '{1'b0, 4'd11, 4'd12, 1'b0, 5'd23, 1'b0},
    '{1'b0, 4'd12, 4'd11, 1'b0, 5'd23, 1'b0},
    '{1'b0, 4'd5,  4'd7,  1'b0, 5'd12, 1'b0},
    '{1'b0, 4'd6,  4'd9,  1'b1, 5'd3,  1'b1},
    '{1'b0, 4'd9,  4'd6,  1'b1, 5'd3,  1'b0},
    '{1'b0, 4'd11, 4'd12, 1'b1, 5'd1,  1'b1},
    '{1'b0, 4'd7,  4'd5,  1'b1, 5'd2,  1'b0},
    '{1'b0, 4'd1,  4'd1,  1'b0, 5'd2,  1'b0},
    '{1'b0, 4'd1,  4'd1,  1'b1, 5'd0,  1'b0},
    '{1'b0, 4'd0,  4'd1,  1'b1, 5'd1,  1'b1},
    '{1'b1, 4'd15, 4'd15, 1'b0, 5'd0,  1'b0},
    '{1'b0, 4'd3,  4'd10, 1'b1, 5'd7,  1'b1},
    '{1'b0, 4'd8,  4'd8,  1'b0, 5'd16, 1'b0},
    '{1'b0, 4'd15, 4'd14, 1'b1, 5'd1,  1'b0}
  };

  // driver: one vector per cycle, expectation queued at issue
  initial begin
    rst = 1'b1;
    a   = 4'd0;
    b   = 4'd0;
    M   = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      a   = vecs[i].a;
      b   = vecs[i].b;
      M   = vecs[i].m;
      q.push_back('{i, vecs[i].es, vecs[i].esign});
    end
    @(negedge clk);
    rst = 1'b0;
    done = 1'b1;
  end

  // monitor: the result of the vector issued before edge N is
  // visible just after edge N
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (s !== e.es || sign !== e.esign) begin
          errors++;
          $display("FAIL vec%0d: s=%0d sign=%b expected s=%0d sign=%b",
                   e.idx, s, sign, e.es, e.esign);
        end
      end
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!(done && q.size() == 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (q.size() != 0 || !done) begin
      errors++;
      $display("FAIL drain: pending=%0d expected pending=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
